// File: rtl/ram_stream_pkg.sv
// Shared constants for the stream-to-RAM controller: default widths,
// arbiter priority encodings and RAM read/write strobe encodings.
package ram_stream_pkg;

    // Default data and address widths; data width must match the RAM.
    localparam int DEF_DW = 8;
    localparam int DEF_AW = 4;

    // Arbiter priority: which side wins the next contended cycle.
    localparam logic PRI_RD = 1'b0;
    localparam logic PRI_WR = 1'b1;

    // RAM rw strobe encodings.
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Pointer increment with natural wrap modulo the RAM depth.
    function automatic logic [DEF_AW-1:0] ptr_inc(input logic [DEF_AW-1:0] p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Grants the single RAM port to either the upstream write or the
// downstream refill read each cycle. Contended cycles alternate winners
// so neither side can starve the other.
module ram_port_arbiter
    import ram_stream_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rd_want,
    input  logic in_valid,
    input  logic wr_ok,
    output logic in_ready,
    output logic wr_go,
    output logic rd_go
);

    logic pri;
    logic contend;

    // Grant terms; in_ready deliberately does not look at in_valid so the
    // upstream handshake has no combinational loop through this block.
    always_comb begin
        in_ready = wr_ok && !(rd_want && (pri == PRI_RD));
        wr_go    = in_valid && in_ready;
        rd_go    = rd_want && !wr_go;
        contend  = rd_want && in_valid && wr_ok;
    end

    // Flip priority only when both sides actually competed, so the loser
    // of this cycle wins the next contended one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri <= PRI_RD;
        end else if (contend) begin
            pri <= ~pri;
        end
    end

endmodule

// File: rtl/ram_stream_ctrl.sv
// Stream-to-RAM controller: stores an incoming valid/ready stream in a
// single-port RAM used as a circular FIFO and replays it in order through
// a registered output holding stage. One RAM access per cycle.
module ram_stream_ctrl
    import ram_stream_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [AW:0]   level,
    output logic          full
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_count;
    logic [DW-1:0] ob;
    logic          ob_v;

    logic rd_want;
    logic wr_ok;
    logic wr_go;
    logic rd_go;

    // Request terms: refill the holding register whenever it is empty or
    // is being drained this cycle and the RAM has something to give.
    always_comb begin
        rd_want = (ram_count != '0) && (!ob_v || out_ready);
        wr_ok   = !full;
    end

    ram_port_arbiter u_arb (
        .clk      (clk),
        .rst      (rst),
        .rd_want  (rd_want),
        .in_valid (in_valid),
        .wr_ok    (wr_ok),
        .in_ready (in_ready),
        .wr_go    (wr_go),
        .rd_go    (rd_go)
    );

    // RAM port steering: write address only on a granted write, otherwise
    // the port idles in read mode pointed at the FIFO head.
    always_comb begin
        ram_rw    = wr_go ? RW_WRITE : RW_READ;
        ram_addr  = wr_go ? wr_ptr : rd_ptr;
        ram_wdata = in_data;
    end

    // Status outputs; level counts the holding register as a stored word.
    always_comb begin
        full      = (ram_count == DEPTH_C);
        level     = ram_count + {{AW{1'b0}}, ob_v};
        out_valid = ob_v;
        out_data  = ob;
    end

    // Pointers and occupancy; write and read grants are mutually
    // exclusive so the count never moves both ways in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
        end else begin
            if (wr_go) begin
                wr_ptr    <= wr_ptr + 1'b1;
                ram_count <= ram_count + 1'b1;
            end else if (rd_go) begin
                rd_ptr    <= rd_ptr + 1'b1;
                ram_count <= ram_count - 1'b1;
            end
        end
    end

    // Output holding register: a read refills it (even while the current
    // word is being consumed, giving back-to-back output); a handshake
    // without a refill just empties it and leaves the data stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            ob   <= '0;
            ob_v <= 1'b0;
        end else if (rd_go) begin
            ob   <= ram_rdata;
            ob_v <= 1'b1;
        end else if (ob_v && out_ready) begin
            ob_v <= 1'b0;
        end
    end

endmodule
